// File: rtl/usb_dbg_bridge_if.sv
// rtl/usb_dbg_bridge_if.sv - byte streams and memory bus of the debug bridge
interface usb_dbg_bridge_if;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  // master: the bridge itself; slave: the usb_cdc / memory environment
  modport master (
    input  out_data_i, out_valid_i, in_ready_i, mem_rdata_i, mem_ack_i,
    output out_ready_o, in_data_o, in_valid_o, mem_req_o, mem_we_o,
    output mem_addr_o, mem_wdata_o
  );

  modport slave (
    output out_data_i, out_valid_i, in_ready_i, mem_rdata_i, mem_ack_i,
    input  out_ready_o, in_data_o, in_valid_o, mem_req_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/usb_dbg_bridge.sv
// rtl/usb_dbg_bridge.sv - byte-command to 32-bit memory bus debug bridge
module usb_dbg_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input logic              clk_i,
  input logic              rstn_i,
  usb_dbg_bridge_if.master io
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  rem_q, rem_d;
  logic        in_valid_q, in_valid_d;
  logic [7:0]  in_data_q, in_data_d;

  logic out_ready;
  logic out_fire;
  logic timeout_hit;

  assign out_ready   = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign out_fire    = io.out_valid_i && out_ready;
  assign timeout_hit = (cnt_q == TIMEOUT - 16'd1);

  // resp_q holds bytes not yet presented, LSB first; rem_q counts them
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    rem_d      = rem_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    case (state_q)
      IDLE: begin
        if (out_fire) begin
          if (io.out_data_i == 8'h01 || io.out_data_i == 8'h02) begin
            we_d    = (io.out_data_i == 8'h01);
            idx_d   = 2'd0;
            state_d = ADDR;
          end else begin
            resp_d  = {32'h0, 8'hEE};
            rem_d   = 3'd1;
            state_d = RESP;
          end
        end
      end
      ADDR: begin
        if (out_fire) begin
          addr_d[{idx_q, 3'b000} +: 8] = io.out_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              cnt_d   = 16'd0;
            end
          end
        end
      end
      DATA: begin
        if (out_fire) begin
          wdata_d[{idx_q, 3'b000} +: 8] = io.out_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = BUS;
            cnt_d   = 16'd0;
          end
        end
      end
      BUS: begin
        // ack wins over a timeout landing in the same cycle
        if (io.mem_ack_i) begin
          resp_d  = we_q ? {32'h0, 8'h81} : {io.mem_rdata_i, 8'h82};
          rem_d   = we_q ? 3'd1 : 3'd5;
          state_d = RESP;
        end else if (timeout_hit) begin
          resp_d  = {32'h0, 8'hEF};
          rem_d   = 3'd1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (!in_valid_q) begin
          in_valid_d = 1'b1;
          in_data_d  = resp_q[7:0];
          resp_d     = {8'h00, resp_q[39:8]};
          rem_d      = rem_q - 3'd1;
        end else if (io.in_ready_i) begin
          if (rem_q == 3'd0) begin
            in_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            in_data_d = resp_q[7:0];
            resp_d    = {8'h00, resp_q[39:8]};
            rem_d     = rem_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      idx_q      <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= 16'd0;
      resp_q     <= 40'h0;
      rem_q      <= 3'd0;
      in_valid_q <= 1'b0;
      in_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rem_q      <= rem_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
    end
  end

  assign io.out_ready_o = out_ready;
  assign io.in_valid_o  = in_valid_q;
  assign io.in_data_o   = in_data_q;
  assign io.mem_req_o   = (state_q == BUS);
  assign io.mem_we_o    = we_q;
  assign io.mem_addr_o  = addr_q;
  assign io.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_usb_dbg_bridge.sv
// tb/tb_usb_dbg_bridge.sv - scoreboard bench for usb_dbg_bridge
module tb_usb_dbg_bridge;
  localparam logic [15:0] TO = 16'd4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  usb_dbg_bridge_if ifc ();
  usb_dbg_bridge #(.TIMEOUT(TO)) dut (.clk_i(clk), .rstn_i(rstn), .io(ifc.master));

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } txn_t;

  txn_t       bus_q[$];
  logic [7:0] resp_q[$];
  int checks = 0;
  int failures = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response side: drive in_ready_i, then score any transfer on the coming edge
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial begin
    ifc.in_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       ifc.in_ready_i = 1'b0;
        2:       ifc.in_ready_i = 1'b1;
        default: ifc.in_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      if (prev_stall && rstn) begin
        chk("in_hold_valid", {31'b0, ifc.in_valid_o}, 32'd1);
        chk("in_hold_data", {24'b0, ifc.in_data_o}, {24'b0, prev_data});
      end
      if (ifc.in_valid_o && ifc.in_ready_i) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual=%h required=none", ifc.in_data_o);
        end else begin
          chk("resp_byte", {24'b0, ifc.in_data_o}, {24'b0, resp_q.pop_front()});
        end
      end
      prev_stall = ifc.in_valid_o && !ifc.in_ready_i;
      prev_data  = ifc.in_data_o;
    end
  end

  // Memory side: check each request against the queued transaction and ack on schedule
  txn_t cur;
  bit   in_req = 1'b0;
  int   k = 0;
  initial begin
    ifc.mem_ack_i   = 1'b0;
    ifc.mem_rdata_i = 32'h0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, delay: 0, rdata: 32'h0};
    forever begin
      @(negedge clk);
      if (ifc.mem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          k = 0;
          if (bus_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req actual=1 required=0");
            cur.delay = 1000;
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("mem_we", {31'b0, ifc.mem_we_o}, {31'b0, cur.we});
        chk("mem_addr", ifc.mem_addr_o, cur.addr);
        if (cur.we) chk("mem_wdata", ifc.mem_wdata_o, cur.wdata);
        ifc.mem_ack_i   = (k == cur.delay);
        ifc.mem_rdata_i = (k == cur.delay) ? cur.rdata : $urandom;
        k++;
      end else begin
        if (in_req) begin
          in_req = 1'b0;
          chk("req_len", k, (cur.delay < int'(TO)) ? cur.delay + 1 : int'(TO));
        end
        ifc.mem_ack_i   = ($urandom_range(0, 3) == 0);
        ifc.mem_rdata_i = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      ifc.out_valid_i = 1'b0;
      ifc.out_data_i  = $urandom;
      repeat (gap) @(negedge clk);
    end
    ifc.out_valid_i = 1'b1;
    ifc.out_data_i  = b;
    n = 0;
    while (!ifc.out_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_stall actual=blocked required=accepted");
    end
    @(posedge clk);
  endtask

  // Reference model: responses follow from opcode, ack delay and TIMEOUT alone
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata, input int gap_max);
    txn_t t;
    bit   cmd;
    cmd = (op == 8'h01 || op == 8'h02);
    if (cmd) begin
      t.we = (op == 8'h01); t.addr = addr; t.wdata = wdata; t.delay = delay; t.rdata = rdata;
      bus_q.push_back(t);
      if (delay < int'(TO)) begin
        if (t.we) resp_q.push_back(8'h81);
        else begin
          resp_q.push_back(8'h82);
          for (int i = 0; i < 4; i++) resp_q.push_back(rdata[8*i +: 8]);
        end
      end else begin
        resp_q.push_back(8'hEF);
      end
    end else begin
      resp_q.push_back(8'hEE);
    end
    send_byte(op, $urandom_range(0, gap_max));
    if (cmd) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(0, gap_max));
      if (op == 8'h01)
        for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], $urandom_range(0, gap_max));
    end
    @(negedge clk);
    ifc.out_valid_i = 1'b0;
    ifc.out_data_i  = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(resp_q.size() == 0 && bus_q.size() == 0 && !ifc.in_valid_o && ifc.out_ready_o)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, (n < 3000)}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_ready"}, {31'b0, ifc.out_ready_o}, 32'd1);
    chk({tag, "_in_valid"}, {31'b0, ifc.in_valid_o}, 32'd0);
    chk({tag, "_in_data"}, {24'b0, ifc.in_data_o}, 32'd0);
    chk({tag, "_mem_req"}, {31'b0, ifc.mem_req_o}, 32'd0);
    chk({tag, "_mem_we"}, {31'b0, ifc.mem_we_o}, 32'd0);
    chk({tag, "_mem_addr"}, ifc.mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, ifc.mem_wdata_o, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] op;
    int r;
    rstn = 1'b0;
    ifc.out_valid_i = 1'b0;
    ifc.out_data_i  = 8'h00;
    #2;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    issue(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0, 0);
    issue(8'h02, 32'h0000_0004, 32'h0, 1, 32'h1234_5678, 0);
    wait_drain("drain_basic");

    issue(8'h02, 32'h0000_0040, 32'h0, 100, 32'hAAAA_5555, 0);
    wait_drain("drain_timeout");
    chk("idle_after_timeout", {31'b0, ifc.out_ready_o}, 32'd1);

    issue(8'h02, 32'h0000_0044, 32'h0, int'(TO) - 1, 32'hCAFE_F00D, 0);
    wait_drain("drain_ack_at_timeout");

    ready_mode = 1;
    issue(8'h55, 32'h0, 32'h0, 0, 32'h0, 0);
    n = 0;
    while (!ifc.in_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {31'b0, ifc.in_valid_o}, 32'd1);
      chk("stall_data", {24'b0, ifc.in_data_o}, 32'h0000_00EE);
      chk("stall_out_ready", {31'b0, ifc.out_ready_o}, 32'd0);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_drain("drain_stall");

    send_byte(8'h02, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    ifc.out_valid_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_vals("midcmd_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    issue(8'h02, 32'h0000_0004, 32'h0, 2, 32'h8765_4321, 0);
    wait_drain("drain_after_reset");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        op = $urandom;
        if (op == 8'h01 || op == 8'h02) op = 8'h00;
      end else begin
        op = (r < 5) ? 8'h01 : 8'h02;
      end
      issue(op, $urandom, $urandom, $urandom_range(0, 6), $urandom, 2);
    end
    wait_drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
